// File: rtl/uart_tx_arb.sv
// ---------------------------------------------------------------------------
// uart_tx_arb
//
// Packet-granular round-robin arbiter in front of the UART transmit FIFO
// write port. Two byte-stream requesters share the FIFO. Once a requester is
// granted, it writes its whole packet of len bytes before the other one can
// start. The transmitter drains the FIFO on its own read side
// (tf_empty/tf_rdreq), which this block does not see.
//
// Parameters:
//   TMO     stall timeout in uart_clk cycles while a granted packet makes no
//           progress (valid low or FIFO full); legal range 2..1023
//   TW      width of the stall counter; must be able to hold TMO
//
// Ports:
//   uart_clk        sole clock (also the transmitter/FIFO write clock)
//   rst_n           asynchronous active-low reset
//   req0/req1       packet request levels, only looked at while idle
//   len0/len1       packet byte counts, captured with the grant (0 = empty)
//   valid0/valid1   a byte is presented on data0/data1
//   data0/data1     byte to write
//   gnt0/gnt1       registered grant, high for the whole packet
//   ack0/ack1       combinational, byte taken this cycle
//   done0/done1     registered one-cycle pulse at packet end
//   err             registered one-cycle pulse when a packet times out
//   tf_full         TX FIFO full
//   tf_wrreq        combinational FIFO write strobe
//   tf_wdata        combinational FIFO write data
// ---------------------------------------------------------------------------
module uart_tx_arb #(
  parameter int unsigned TMO = 1023,
  parameter int unsigned TW  = 10
) (
  input  logic       uart_clk,
  input  logic       rst_n,
  input  logic       req0,
  input  logic       req1,
  input  logic [7:0] len0,
  input  logic [7:0] len1,
  input  logic       valid0,
  input  logic       valid1,
  input  logic [7:0] data0,
  input  logic [7:0] data1,
  output logic       gnt0,
  output logic       gnt1,
  output logic       ack0,
  output logic       ack1,
  output logic       done0,
  output logic       done1,
  output logic       err,
  input  logic       tf_full,
  output logic       tf_wrreq,
  output logic [7:0] tf_wdata
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    DONE = 2'd2
  } state_t;

  // Stall-counter value on which the last tolerated idle cycle ends.
  localparam logic [TW-1:0] TCNT_LAST = TW'(TMO - 1);

  state_t        state, state_n;
  logic          sel, sel_n;
  logic          last, last_n;
  logic [7:0]    rem, rem_n;
  logic [TW-1:0] tcnt, tcnt_n;
  logic          gnt0_n, gnt1_n;
  logic          done0_n, done1_n;
  logic          err_n;

  logic          valid_sel;
  logic [7:0]    data_sel;
  logic          accept;
  logic          pick;
  logic [7:0]    len_sel;

  // Data path of whichever requester currently owns the FIFO.
  assign valid_sel = sel ? valid1 : valid0;
  assign data_sel  = sel ? data1  : data0;
  assign accept    = valid_sel & ~tf_full;

  // State and bookkeeping registers. last starts at 1 so requester 0 wins
  // the very first contention. A reset mid-packet simply drops the packet;
  // no done or err pulse is generated for it.
  always_ff @(posedge uart_clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      sel   <= 1'b0;
      last  <= 1'b1;
      rem   <= 8'd0;
      tcnt  <= '0;
      gnt0  <= 1'b0;
      gnt1  <= 1'b0;
      done0 <= 1'b0;
      done1 <= 1'b0;
      err   <= 1'b0;
    end else begin
      state <= state_n;
      sel   <= sel_n;
      last  <= last_n;
      rem   <= rem_n;
      tcnt  <= tcnt_n;
      gnt0  <= gnt0_n;
      gnt1  <= gnt1_n;
      done0 <= done0_n;
      done1 <= done1_n;
      err   <= err_n;
    end
  end

  // Next-state and output logic.
  // IDLE picks a requester (alternating under contention) and captures its
  // length; an empty packet skips straight to DONE so it still gets a done
  // pulse. XFER moves one byte per cycle whenever the owner has data and the
  // FIFO has room; any cycle without progress advances the stall counter,
  // and reaching the timeout abandons the packet with an err pulse. DONE is
  // a single cycle that drops the grant, pulses done and records the owner
  // for round-robin purposes, whether the packet finished, aborted or was
  // empty.
  always_comb begin
    state_n  = state;
    sel_n    = sel;
    last_n   = last;
    rem_n    = rem;
    tcnt_n   = tcnt;
    gnt0_n   = gnt0;
    gnt1_n   = gnt1;
    done0_n  = 1'b0;
    done1_n  = 1'b0;
    err_n    = 1'b0;
    tf_wrreq = 1'b0;
    tf_wdata = 8'd0;
    ack0     = 1'b0;
    ack1     = 1'b0;
    pick     = 1'b0;
    len_sel  = 8'd0;

    case (state)
      IDLE: begin
        if (req0 | req1) begin
          // Under contention the requester that did not go last wins.
          pick    = (req0 & req1) ? ~last : req1;
          len_sel = pick ? len1 : len0;
          sel_n   = pick;
          rem_n   = len_sel;
          tcnt_n  = '0;
          gnt0_n  = ~pick;
          gnt1_n  = pick;
          state_n = (len_sel != 8'd0) ? XFER : DONE;
        end
      end

      XFER: begin
        tf_wrreq = accept;
        tf_wdata = data_sel;
        ack0     = accept & ~sel;
        ack1     = accept & sel;
        if (accept) begin
          rem_n  = rem - 8'd1;
          tcnt_n = '0;
          if (rem == 8'd1) begin
            state_n = DONE;
          end
        end else begin
          tcnt_n = tcnt + 1'b1;
          if (tcnt == TCNT_LAST) begin
            state_n = DONE;
            err_n   = 1'b1;
          end
        end
      end

      DONE: begin
        gnt0_n  = 1'b0;
        gnt1_n  = 1'b0;
        done0_n = ~sel;
        done1_n = sel;
        last_n  = sel;
        state_n = IDLE;
      end

      default: begin
        state_n = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_tx_arb.sv
// ---------------------------------------------------------------------------
// tb_uart_tx_arb
//
// Self-checking bench for uart_tx_arb. Each packet is modelled as a
// transaction: the bench decides the winner from the round-robin rule, builds
// the packet bytes, chooses per cycle whether the owner presents data and
// whether the FIFO is full, and from that alone predicts grants, acks,
// writes, data, done/err pulses and the write count. The stall timeout is
// shortened to 8 cycles so aborts are cheap to provoke.
// ---------------------------------------------------------------------------
module tb_uart_tx_arb;

  localparam int TMO = 8;

  logic       uart_clk = 1'b0;
  logic       rst_n;
  logic       req0, req1;
  logic [7:0] len0, len1;
  logic       valid0, valid1;
  logic [7:0] data0, data1;
  logic       tf_full;
  logic       gnt0, gnt1, ack0, ack1, done0, done1, err, tf_wrreq;
  logic [7:0] tf_wdata;

  int tests_run    = 0;
  int tests_failed = 0;

  // Reference-model state: who went last, and whose done pulse is due.
  int rr_last   = 1;
  int pend_done = -1;

  int nwr;

  uart_tx_arb #(.TMO(TMO), .TW(10)) dut (
    .uart_clk (uart_clk),
    .rst_n    (rst_n),
    .req0     (req0),
    .req1     (req1),
    .len0     (len0),
    .len1     (len1),
    .valid0   (valid0),
    .valid1   (valid1),
    .data0    (data0),
    .data1    (data1),
    .gnt0     (gnt0),
    .gnt1     (gnt1),
    .ack0     (ack0),
    .ack1     (ack1),
    .done0    (done0),
    .done1    (done1),
    .err      (err),
    .tf_full  (tf_full),
    .tf_wrreq (tf_wrreq),
    .tf_wdata (tf_wdata)
  );

  always #5 uart_clk = ~uart_clk;

  // Single comparison point: counts, asserts, reports.
  task automatic checkOne(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("[TB] FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle's inputs just after the rising edge.
  task automatic applyStimulus(input logic r0, input logic r1,
                               input logic [7:0] l0, input logic [7:0] l1,
                               input logic v0, input logic v1,
                               input logic [7:0] d0, input logic [7:0] d1,
                               input logic full);
    @(posedge uart_clk);
    #1;
    req0 = r0;  req1 = r1;
    len0 = l0;  len1 = l1;
    valid0 = v0; valid1 = v1;
    data0 = d0; data1 = d1;
    tf_full = full;
  endtask

  // Compare every output mid-cycle against the predicted values.
  task automatic checkOutput(input string tag,
                             input logic e_gnt0, input logic e_gnt1,
                             input logic e_ack0, input logic e_ack1,
                             input logic e_done0, input logic e_done1,
                             input logic e_err, input logic e_wrreq,
                             input logic [7:0] e_wdata);
    #1;
    checkOne({tag, ".gnt0"},  8'(gnt0),  8'(e_gnt0));
    checkOne({tag, ".gnt1"},  8'(gnt1),  8'(e_gnt1));
    checkOne({tag, ".ack0"},  8'(ack0),  8'(e_ack0));
    checkOne({tag, ".ack1"},  8'(ack1),  8'(e_ack1));
    checkOne({tag, ".done0"}, 8'(done0), 8'(e_done0));
    checkOne({tag, ".done1"}, 8'(done1), 8'(e_done1));
    checkOne({tag, ".err"},   8'(err),   8'(e_err));
    checkOne({tag, ".wrreq"}, 8'(tf_wrreq), 8'(e_wrreq));
    checkOne({tag, ".wdata"}, tf_wdata, e_wdata);
    checkOne({tag, ".overlap"}, 8'(gnt0 & gnt1), 8'd0);
  endtask

  // One idle cycle with no requests; collects any pending done pulse.
  task automatic finalIdle(input string tag);
    applyStimulus(1'b0, 1'b0, 8'd0, 8'd0, 1'b0, 1'b0, 8'd0, 8'd0, 1'b0);
    checkOutput(tag, 1'b0, 1'b0, 1'b0, 1'b0, 1'(pend_done == 0), 1'(pend_done == 1),
                1'b0, 1'b0, 8'd0);
    pend_done = -1;
  endtask

  // One full arbitration round starting in IDLE.
  //   base >= 0       : packet bytes are base, base+1, ...; otherwise random
  //   pv / pf         : percent chance of valid high / FIFO full per cycle
  //   drop_after >= 0 : owner stops presenting data after that many bytes
  //   full_after >= 0 : FIFO forced full for full_len cycles once that many
  //                     bytes have gone through
  //   hold            : keep requests high through the closing cycle
  //   writes          : writes actually observed on tf_wrreq
  task automatic runPacket(input string name, input bit r0, input bit r1,
                           input int l0, input int l1, input int base,
                           input int pv, input int pf, input int drop_after,
                           input int full_after, input int full_len,
                           input bit hold, output int writes);
    int who, plen, idx, stall, fcnt;
    bit aborted, v, f, acc;
    logic [7:0] pkt[$];

    applyStimulus(r0, r1, 8'(l0), 8'(l1), 1'b0, 1'b0, 8'($urandom), 8'($urandom), 1'b0);
    checkOutput({name, "/arb"}, 1'b0, 1'b0, 1'b0, 1'b0,
                1'(pend_done == 0), 1'(pend_done == 1), 1'b0, 1'b0, 8'd0);
    pend_done = -1;

    who  = (r0 && r1) ? ((rr_last == 1) ? 0 : 1) : (r0 ? 0 : 1);
    plen = (who == 1) ? l1 : l0;
    for (int i = 0; i < plen; i++) begin
      pkt.push_back((base >= 0) ? 8'(base + i) : 8'($urandom));
    end

    idx = 0; stall = 0; fcnt = 0; aborted = 1'b0; writes = 0;
    while (idx < plen && !aborted) begin
      v = (drop_after >= 0 && idx >= drop_after) ? 1'b0 : (int'($urandom_range(99)) < pv);
      if (full_after >= 0 && idx >= full_after && fcnt < full_len) begin
        f = 1'b1;
        fcnt++;
      end else begin
        f = (int'($urandom_range(99)) < pf);
      end
      acc = v && !f;
      if (who == 0)
        applyStimulus(r0, r1, 8'(l0), 8'(l1), v, 1'($urandom_range(1)),
                      pkt[idx], 8'($urandom), f);
      else
        applyStimulus(r0, r1, 8'(l0), 8'(l1), 1'($urandom_range(1)), v,
                      8'($urandom), pkt[idx], f);
      checkOutput({name, "/xfer"}, 1'(who == 0), 1'(who == 1),
                  acc && (who == 0), acc && (who == 1), 1'b0, 1'b0, 1'b0,
                  acc, pkt[idx]);
      if (tf_wrreq === 1'b1) writes++;
      if (acc) begin
        idx++;
        stall = 0;
      end else begin
        stall++;
        if (stall == TMO) aborted = 1'b1;
      end
    end

    applyStimulus(hold ? r0 : 1'b0, hold ? r1 : 1'b0, 8'(l0), 8'(l1),
                  1'($urandom_range(1)), 1'($urandom_range(1)),
                  8'($urandom), 8'($urandom), 1'($urandom_range(1)));
    checkOutput({name, "/done"}, 1'(who == 0), 1'(who == 1), 1'b0, 1'b0,
                1'b0, 1'b0, aborted, 1'b0, 8'd0);
    checkOne({name, "/count"}, 8'(writes), 8'(idx));

    rr_last   = who;
    pend_done = who;
  endtask

  initial begin
    rst_n = 1'b0;
    req0 = 1'b0; req1 = 1'b0; len0 = 8'd0; len1 = 8'd0;
    valid0 = 1'b0; valid1 = 1'b0; data0 = 8'd0; data1 = 8'd0; tf_full = 1'b0;

    // Reset state, with requests and data active to show they are ignored.
    applyStimulus(1'b1, 1'b1, 8'd3, 8'd3, 1'b1, 1'b1, 8'h11, 8'h22, 1'b0);
    checkOutput("reset", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
    applyStimulus(1'b0, 1'b0, 8'd0, 8'd0, 1'b0, 1'b0, 8'd0, 8'd0, 1'b0);
    rst_n = 1'b1;
    checkOutput("post_reset", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);

    // Contention held through two packets: 0 then 1, one idle cycle between.
    runPacket("contend_a", 1'b1, 1'b1, 2, 2, -1, 100, 0, -1, -1, 0, 1'b1, nwr);
    checkOne("contend_a_writes", 8'(nwr), 8'd2);
    runPacket("contend_b", 1'b1, 1'b1, 2, 2, -1, 100, 0, -1, -1, 0, 1'b0, nwr);
    checkOne("contend_b_writes", 8'(nwr), 8'd2);
    finalIdle("contend_end");

    // Basic three-byte packet from requester 0 carrying 0x41..0x43.
    runPacket("basic", 1'b1, 1'b0, 3, 0, 8'h41, 100, 0, -1, -1, 0, 1'b0, nwr);
    checkOne("basic_writes", 8'(nwr), 8'd3);
    finalIdle("basic_end");

    // FIFO full for 5 cycles after the second byte; no timeout.
    runPacket("fullstall", 1'b0, 1'b1, 0, 4, -1, 100, 0, -1, 2, 5, 1'b0, nwr);
    checkOne("fullstall_writes", 8'(nwr), 8'd4);
    finalIdle("fullstall_end");

    // Owner stops after 2 of 5 bytes: timeout abort with err and done.
    runPacket("abort", 1'b1, 1'b0, 5, 0, -1, 100, 0, 2, -1, 0, 1'b0, nwr);
    checkOne("abort_writes", 8'(nwr), 8'd2);
    // Next contention must go to requester 1.
    runPacket("after_abort", 1'b1, 1'b1, 1, 1, -1, 100, 0, -1, -1, 0, 1'b0, nwr);
    finalIdle("after_abort_end");

    // Empty packet: one grant cycle, done, no writes.
    runPacket("empty", 1'b1, 1'b0, 0, 0, -1, 100, 0, -1, -1, 0, 1'b0, nwr);
    checkOne("empty_writes", 8'(nwr), 8'd0);
    finalIdle("empty_end");

    // Longest packet.
    runPacket("len255", 1'b0, 1'b1, 0, 255, -1, 100, 0, -1, -1, 0, 1'b0, nwr);
    checkOne("len255_writes", 8'(nwr), 8'd255);
    finalIdle("len255_end");

    // Randomised traffic: random owners, lengths, valid gaps, FIFO back-pressure.
    for (int p = 0; p < 24; p++) begin
      bit r0, r1;
      r0 = 1'($urandom_range(1));
      r1 = r0 ? 1'($urandom_range(1)) : 1'b1;
      runPacket($sformatf("rand%0d", p), r0, r1, int'($urandom_range(10)),
                int'($urandom_range(10)), -1, 60 + int'($urandom_range(40)),
                int'($urandom_range(30)), -1, -1, 0, 1'($urandom_range(1)), nwr);
    end
    finalIdle("rand_end");

    // Reset in the middle of a 4-byte packet after its first byte.
    applyStimulus(1'b1, 1'b0, 8'd4, 8'd0, 1'b0, 1'b0, 8'd0, 8'd0, 1'b0);
    checkOutput("midrst/arb", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
    applyStimulus(1'b1, 1'b0, 8'd4, 8'd0, 1'b1, 1'b0, 8'h55, 8'd0, 1'b0);
    checkOutput("midrst/b1", 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h55);
    applyStimulus(1'b1, 1'b0, 8'd4, 8'd0, 1'b1, 1'b0, 8'h56, 8'd0, 1'b0);
    rst_n = 1'b0;
    checkOutput("midrst/now", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
    applyStimulus(1'b0, 1'b0, 8'd0, 8'd0, 1'b1, 1'b0, 8'h57, 8'd0, 1'b0);
    checkOutput("midrst/hold", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
    applyStimulus(1'b0, 1'b0, 8'd0, 8'd0, 1'b0, 1'b0, 8'd0, 8'd0, 1'b0);
    rst_n = 1'b1;
    checkOutput("midrst/release", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
    rr_last   = 1;
    pend_done = -1;
    runPacket("midrst/after", 1'b0, 1'b1, 0, 1, -1, 100, 0, -1, -1, 0, 1'b0, nwr);
    checkOne("midrst_after_writes", 8'(nwr), 8'd1);
    finalIdle("midrst_end");

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/uart_tx_arb.md
Name: uart_tx_arb

Overview:
- Packet-granular round-robin arbiter that shares the single UART transmit FIFO between two byte-stream requesters.
- Examples of requesters: command-response logic and a debug/status reporter.
- The granted requester writes a whole packet of len bytes into the FIFO before the other requester may start.
- Sits on the FIFO write side, upstream of the transmitter, which drains the FIFO through tf_empty/tf_rdreq.

Parameters:
- TMO, 1023: stall timeout, in uart_clk cycles, with a granted requester's valid low mid-packet; range 2..1023.
- TW, 10: width of the timeout counter; must hold TMO.

Ports:
- uart_clk  in  1  sole clock; also clocks the transmitter and the FIFO write port.
- rst_n  in  1  asynchronous active-low reset.
- req0, req1  in  1  packet request; level, sampled only in IDLE.
- len0, len1  in  8  packet byte count; sampled with the grant; 0 = empty packet.
- valid0, valid1  in  1  data byte available on data0/data1.
- data0, data1  in  8  byte to write.
- gnt0, gnt1  out  1  registered grant; high for the whole packet.
- ack0, ack1  out  1  combinational; byte accepted this cycle.
- done0, done1  out  1  registered one-cycle pulse at packet end.
- err  out  1  registered one-cycle pulse when a packet is aborted by timeout.
- tf_full  in  1  TX FIFO full.
- tf_wrreq  out  1  combinational FIFO write strobe.
- tf_wdata  out  8  combinational FIFO write data.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, last=1 (so requester 0 wins the first contention).
  - rem=0, tcnt=0.
  - gnt*, done*, err = 0.
  - tf_wrreq=0, ack*=0.
- States: IDLE, XFER, DONE. Reset mid-packet abandons the packet silently; no done or err pulse.
- IDLE:
  - Only req0 high: sel=0. Only req1 high: sel=1.
  - Both high: sel = ~last.
  - On a selection: rem<=len_sel, tcnt<=0, gnt_sel<=1 (visible the next cycle).
  - Next state is XFER if len_sel!=0, else DONE.
  - No request: stay in IDLE.
- XFER:
  - accept = valid_sel & ~tf_full.
  - tf_wrreq=accept, tf_wdata=data_sel, ack_sel=accept; the other ack stays 0.
  - When not in XFER: tf_wrreq=0, tf_wdata=0.
  - On accept: rem<=rem-1, tcnt<=0. If rem==1, go to DONE.
  - Without accept: tcnt<=tcnt+1. If tcnt==TMO-1, go to DONE and pulse err in the same transition.
  - tcnt counts both valid-low cycles and FIFO-full cycles. The transmitter always drains the FIFO, so a full FIFO cannot stall forever.
  - The other requester's req is ignored in XFER.
- DONE (exactly one cycle):
  - gnt_sel<=0, done_sel<=1 for one cycle, last<=sel, then IDLE.
  - done pulses on normal completion, abort and len==0 alike.
- Requester rules:
  - Deassert req no later than the cycle done pulses. req still high when IDLE is re-entered is treated as a new packet.
  - Minimum gap between two grants is 1 IDLE cycle.
  - Latency: req high in IDLE -> gnt high 1 cycle later -> first tf_wrreq possible that same cycle.
- Throughput: 1 byte per cycle while valid_sel=1 and tf_full=0.
- Boundary cases:
  - len=255: 255 writes; rem is 8 bits, with no wrap issue.
  - tf_full rising while valid is held: no write, no ack; the byte must be held.
  - Simultaneous req0/req1 after an abort: the round-robin pointer still advances.
- Invariants:
  - gnt0 & gnt1 is never 1.
  - Exactly len_sel writes per non-aborted packet.

Test Plan:
- Reset then req0=1, len0=3, valid0 always 1, tf_full=0 -> gnt0 one cycle later; tf_wrreq high 3 consecutive cycles with data0 bytes 0x41,0x42,0x43; done0 pulses once; gnt0 falls.
- req0 and req1 both held high with len=2 each, through two packets -> grant order 0 then 1; each packet writes 2 bytes; gnt0/gnt1 never overlap; 1 idle cycle between packets.
- req1, len1=4; tf_full=1 for 5 cycles after the 2nd byte -> writes pause with ack1=0; 4 writes total; no err (TMO=1023).
- TMO=8 override; req0, len0=5, valid0 dropped after 2 bytes -> err pulses 8 cycles after the last accept; done0 pulses; exactly 2 writes; next contention grants requester 1.
- req0 with len0=0 -> gnt0 high 1 cycle; done0 pulses; zero tf_wrreq.
- rst_n low mid-packet (after byte 1 of 4) -> gnt*, tf_wrreq, done* and err all 0 immediately; after release, req1 alone with len1=1 -> 1 write.
